// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy engine: FSM states, bus widths and
// the address-range helper used when a copy is accepted.
package mem_copy_engine_pkg;

  localparam int unsigned WORD_W             = 32;
  localparam int unsigned SUM_W              = WORD_W + 1;
  localparam int unsigned ADDR_LIMIT_DEFAULT = 2048;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_e;

  // True when base..base+len-1 would reach past the last valid word address.
  function automatic logic range_bad(input logic [WORD_W-1:0] base,
                                     input logic [WORD_W-1:0] len,
                                     input int unsigned       limit);
    return (SUM_W'(base) + SUM_W'(len)) > SUM_W'(limit);
  endfunction

endpackage

// File: rtl/mem_copy_engine_if.sv
// Word-addressed memory bus between the copy engine (master) and a
// zero-latency memory (slave).
interface mem_copy_engine_if;
  import mem_copy_engine_pkg::*;

  logic [WORD_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [WORD_W-1:0] mem_writedata;
  logic [WORD_W-1:0] mem_readdata;

  modport master (
    output mem_address,
    output mem_read,
    output mem_write,
    output mem_writedata,
    input  mem_readdata
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    input  mem_write,
    input  mem_writedata,
    output mem_readdata
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: alternating READ/WRITE bus cycles with a
// range check at start, abort support and a one-cycle done pulse.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [WORD_W-1:0] src_i,
  input  logic [WORD_W-1:0] dst_i,
  input  logic [WORD_W-1:0] len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [WORD_W-1:0] words_copied_o,
  mem_copy_engine_if.master mem
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] src_q, src_d;
  logic [WORD_W-1:0] dst_q, dst_d;
  logic [WORD_W-1:0] rem_q, rem_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  // Next-state logic; bus outputs are decoded from the next state so that the
  // registered strobes line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src_d = src_i;
          dst_d = dst_i;
          rem_d = len_i;
          cnt_d = '0;
          if (len_i == '0) begin
            err_d   = 1'b0;
            state_d = ST_DONE;
          end else if (range_bad(src_i, len_i, ADDR_LIMIT) ||
                       range_bad(dst_i, len_i, ADDR_LIMIT)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        data_d  = mem.mem_readdata;
        state_d = abort_i ? ST_DONE : ST_WRITE;
      end
      ST_WRITE: begin
        src_d   = src_q + WORD_W'(1);
        dst_d   = dst_q + WORD_W'(1);
        rem_d   = rem_q - WORD_W'(1);
        cnt_d   = cnt_q + WORD_W'(1);
        state_d = (abort_i || rem_q == WORD_W'(1)) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_d    = (state_d == ST_READ);
    wr_d    = (state_d == ST_WRITE);
    busy_d  = rd_d | wr_d;
    done_d  = (state_d == ST_DONE);
    addr_d  = rd_d ? src_d : (wr_d ? dst_d : '0);
    wdata_d = wr_d ? data_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign error_o           = err_q;
  assign words_copied_o    = cnt_q;
  assign mem.mem_read      = rd_q;
  assign mem.mem_write     = wr_q;
  assign mem.mem_address   = addr_q;
  assign mem.mem_writedata = wdata_q;

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter ADDR_LIMIT, default 2048, number of valid word addresses on the memory bus.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a copy; honoured only in IDLE.
REQ-005 abort  input  1  terminate an in-progress copy.
REQ-006 src  input  32  source word address, latched on accepted start.
REQ-007 dst  input  32  destination word address, latched on accepted start.
REQ-008 len  input  32  word count, latched on accepted start.
REQ-009 busy  output  1  high in READ and WRITE states.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 error  output  1  valid with done; 1 = range violation, no bus activity.
REQ-012 words_copied  output  32  count of completed word writes in the current/last copy.
REQ-013 mem_address  output  32  word address to memory.
REQ-014 mem_read  output  1  read strobe.
REQ-015 mem_write  output  1  write strobe.
REQ-016 mem_writedata  output  32  write data.
REQ-017 mem_readdata  input  32  read data, valid combinationally in the same cycle as mem_read (zero-latency memory).

Function
REQ-018 States: IDLE, READ, WRITE, DONE; encoding is implementation-defined.
REQ-019 IDLE + start: latch src/dst/len, clear words_copied; len==0 -> DONE (error=0); src+len>ADDR_LIMIT or dst+len>ADDR_LIMIT (33-bit unsigned sums) -> DONE with error=1; otherwise -> READ.
REQ-020 READ: mem_read=1, mem_address=src pointer; mem_readdata captured into a data register at the clock edge; next state WRITE.
REQ-021 WRITE: mem_write=1, mem_address=dst pointer, mem_writedata=data register; at the edge both pointers +1, remaining -1, words_copied +1; next state DONE if remaining was 1, else READ.
REQ-022 DONE: done=1 for exactly one cycle, error held from the start decision; next state IDLE.
REQ-023 mem_read and mem_write are never high in the same cycle; outside READ/WRITE both are 0, mem_address=0, mem_writedata=0.
REQ-024 Latency: N-word copy uses 2N bus cycles; done asserts in cycle 2N+1 after the start cycle; len==0 or error gives done in cycle 1.
REQ-025 abort high in READ or WRITE: current cycle's strobe is not gated and completes; next state is DONE with error=0; words_copied reflects writes completed, including one in that cycle.
REQ-026 abort in IDLE or DONE is ignored; start outside IDLE is ignored.
REQ-027 start and abort simultaneously in IDLE: start accepted, abort ignored.
REQ-028 Pointers never wrap within a legal copy; the range check guarantees addresses < ADDR_LIMIT.
REQ-029 error retains its value until the next accepted start; done is registered, not combinational.

Reset
REQ-030 reset at any clock edge, including mid-copy, forces IDLE; busy=0, done=0, error=0, words_copied=0, all mem_* outputs 0; no partial strobe in the following cycle.
REQ-031 reset has priority over start and abort.

Structure
REQ-032 State enum and default ADDR_LIMIT constant reside in the shared memory-bus package.
REQ-033 Single flat module; no sub-module required.

Verification
REQ-034 Memory words 0x10..0x13 preset = 0xA0..0xA3; start src=0x10 dst=0x100 len=4 -> alternating read/write for 8 cycles, done at cycle 9, words 0x100..0x103 = 0xA0..0xA3, words_copied=4, error=0.
REQ-035 start len=0 -> done next cycle, error=0, no mem_read/mem_write ever asserted.
REQ-036 start src=2040 dst=0 len=9 -> done next cycle, error=1, no bus activity; len=8 from 2040 succeeds.
REQ-037 len=10, abort asserted in the third WRITE cycle -> done next cycle, words_copied=3, only dst..dst+2 modified.
REQ-038 reset asserted during a READ of a len=5 copy -> next cycle all outputs 0, state IDLE; a fresh start then copies correctly.
REQ-039 Every cycle: assertion that mem_read and mem_write are never both 1, and busy==(mem_read|mem_write).
